// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences the camera-path PLL out of reset, waits for its lock indicator
//   to stay continuously asserted for STABLE_CYCLES reference cycles, and only
//   then releases the downstream active-low reset. A drop of lock while
//   running re-resets the PLL and bumps a saturating relock counter.
//
//   Optional build macro: PLL_LOCK_SUPERVISOR_TIMEOUT_EN
//     When defined, WAIT_LOCK gives up after LOCK_TIMEOUT cycles without lock
//     and pulses the PLL reset again. When undefined, WAIT_LOCK waits forever.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             lock_lost,
    output logic [CNT_W-1:0] relock_count,
    output logic [1:0]       state_o
);

    // Counter must hold the largest terminal value of any state that counts.
    localparam int MAX_A    = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CYC  = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CNT_BITS = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_BITS-1:0] RST_LAST = CNT_BITS'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] STB_LAST = CNT_BITS'(STABLE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_W-1:0]    REL_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    REL_ONE  = CNT_W'(1);
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
    localparam logic [CNT_BITS-1:0] TO_LAST  = CNT_BITS'(LOCK_TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_n_q, sys_rst_n_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0]       relock_count_q, relock_count_d;
    logic                   lock_s;

    // Shift the asynchronous lock indicator through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Next-state, cycle counter and next-output decode for the lock sequence.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pll_rst_d      = 1'b0;
        sys_rst_n_d    = 1'b0;
        lock_lost_d    = 1'b0;
        relock_count_d = relock_count_q;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = CNT_ZERO;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    pll_rst_d = 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    // Lock on the timeout cycle still counts as lock.
                    state_d = STABLE;
                    cnt_d   = CNT_ZERO;
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    // Timeout re-resets the PLL but is not a relock event.
                    state_d   = RESET_PLL;
                    cnt_d     = CNT_ZERO;
                    pll_rst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`else
                end else begin
                    cnt_d = CNT_ZERO;
                end
`endif
            end
            STABLE: begin
                if (!lock_s) begin
                    // Any drop discards the accumulated stable time.
                    state_d = WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == STB_LAST) begin
                    state_d     = RUN;
                    cnt_d       = CNT_ZERO;
                    sys_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d     = RESET_PLL;
                    cnt_d       = CNT_ZERO;
                    pll_rst_d   = 1'b1;
                    lock_lost_d = 1'b1;
                    if (relock_count_q != REL_MAX) begin
                        relock_count_d = relock_count_q + REL_ONE;
                    end else begin
                        relock_count_d = relock_count_q;
                    end
                end else begin
                    sys_rst_n_d = 1'b1;
                end
            end
            default: begin
                state_d   = RESET_PLL;
                cnt_d     = CNT_ZERO;
                pll_rst_d = 1'b1;
            end
        endcase
    end

    // State, counter, synchroniser and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RESET_PLL;
            cnt_q          <= CNT_ZERO;
            sync_q         <= {SYNC_STAGES{1'b0}};
            pll_rst_q      <= 1'b1;
            sys_rst_n_q    <= 1'b0;
            lock_lost_q    <= 1'b0;
            relock_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync_q         <= sync_d;
            pll_rst_q      <= pll_rst_d;
            sys_rst_n_q    <= sys_rst_n_d;
            lock_lost_q    <= lock_lost_d;
            relock_count_q <= relock_count_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst_n    = sys_rst_n_q;
    assign lock_lost    = lock_lost_q;
    assign relock_count = relock_count_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters:
// PLL_RST_CYCLES=4, STABLE_CYCLES=8, SYNC_STAGES=2, LOCK_TIMEOUT=20, CNT_W=2.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_lost;
    logic [1:0] relock_count;
    logic [1:0] state_o;

    int vectors;
    int miscompares;
    int n;
    int highs;

    pll_lock_supervisor #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .STABLE_CYCLES (8),
        .LOCK_TIMEOUT  (20),
        .CNT_W         (2)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .lock_lost   (lock_lost),
        .relock_count(relock_count),
        .state_o     (state_o)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // sel: 0 pll_rst, 1 sys_rst_n, 2 state_o==STABLE
    function automatic logic probe(input int sel);
        if (sel == 0)      return pll_rst;
        else if (sel == 1) return sys_rst_n;
        else               return (state_o == 2'd2);
    endfunction

    // Ticks until the probed signal equals val; returns bound on expiry.
    task automatic count_until(input int sel, input logic val, input int bound, output int cnt);
        cnt = 0;
        while (probe(sel) !== val && cnt < bound) begin
            tick();
            cnt++;
        end
    endtask

    task automatic lose_lock(input logic [1:0] exp_rel);
        int k;
        pll_locked = 1'b0;
        count_until(1, 1'b0, 20, k);
        check("loss_latency", k, 3);
        check("loss_lock_lost", lock_lost, 1'b1);
        check("loss_pll_rst", pll_rst, 1'b1);
        check("loss_state", state_o, 2'd0);
        check("loss_relock", relock_count, exp_rel);
        tick();
        check("loss_pulse_end", lock_lost, 1'b0);
        count_until(0, 1'b0, 20, k);
        check("loss_rst_rest", k, 3);
    endtask

    task automatic relock(input int exp_n);
        int k;
        pll_locked = 1'b1;
        count_until(1, 1'b1, 200, k);
        check("relock_latency", k, exp_n);
        check("relock_state", state_o, 2'd3);
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        vectors     = 0;
        miscompares = 0;
        sat_exp     = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst_n       = 1'b0;
        pll_locked  = 1'b0;

        // Reset values
        tick(); tick(); tick();
        check("rst_state", state_o, 2'd0);
        check("rst_pll_rst", pll_rst, 1'b1);
        check("rst_sys_rst_n", sys_rst_n, 1'b0);
        check("rst_lock_lost", lock_lost, 1'b0);
        check("rst_relock", relock_count, 2'd0);

        // Power-up: pll_rst high exactly 4 cycles, lock 3 cycles later, 11 to release
        rst_n = 1'b1;
        count_until(0, 1'b0, 50, n);
        check("pu_pll_rst_width", n, 4);
        check("pu_wait_state", state_o, 2'd1);
        tick(); tick(); tick();
        pll_locked = 1'b1;
        count_until(1, 1'b1, 100, n);
        check("pu_release_latency", n, 11);
        check("pu_run_state", state_o, 2'd3);
        check("pu_relock", relock_count, 2'd0);
        check("pu_pll_rst_low", pll_rst, 1'b0);

        // First loss in RUN
        lose_lock(2'd1);

        // Flicker in STABLE: drop at cnt=5 so the loss lands on the completion cycle
        pll_locked = 1'b1;
        count_until(2, 1'b1, 50, n);
        check("fl_enter_stable", n, 3);
        tick(); tick(); tick(); tick(); tick();
        pll_locked = 1'b0;
        tick(); tick();
        pll_locked = 1'b1;
        tick();
        check("fl_back_to_wait", state_o, 2'd1);
        check("fl_sys_rst_n_low", sys_rst_n, 1'b0);
        count_until(2, 1'b1, 50, n);
        check("fl_reenter_stable", n, 2);
        count_until(1, 1'b1, 50, n);
        check("fl_full_stable_again", n, 8);
        check("fl_run_state", state_o, 2'd3);

        // Second loss, relock to RUN with relock_count=2
        lose_lock(2'd2);
        relock(11);
        check("pre_reset_relock", relock_count, 2'd2);

        // Mid-operation asynchronous reset, no clock edge needed
        rst_n = 1'b0;
        #1;
        check("mid_pll_rst", pll_rst, 1'b1);
        check("mid_sys_rst_n", sys_rst_n, 1'b0);
        check("mid_relock", relock_count, 2'd0);
        check("mid_state", state_o, 2'd0);
        check("mid_lock_lost", lock_lost, 1'b0);

        // Restart with lock already present, then saturate relock_count
        tick();
        rst_n = 1'b1;
        relock(13);
        for (int i = 0; i < 5; i++) begin
            lose_lock(sat_exp[i]);
            if (i < 4) relock(11);
        end

        // Lock held low from reset: timeout behaviour
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_until(0, 1'b0, 50, n);
        check("to_first_pulse", n, 4);
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
        count_until(0, 1'b1, 100, n);
        check("to_wait_len", n, 20);
        count_until(0, 1'b0, 100, n);
        check("to_repulse_width", n, 4);
        count_until(0, 1'b1, 100, n);
        check("to_wait_len2", n, 20);
        check("to_relock", relock_count, 2'd0);
`else
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pll_rst) highs++;
        end
        check("no_to_pll_rst_highs", highs, 0);
        check("no_to_state", state_o, 2'd1);
        check("no_to_relock", relock_count, 2'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
